// File: rtl/sme.sv
// ---------------------------------------------------------------------------
// sme - String Matching Engine
//
// Stores one text string (up to STR_MAX characters) and searches it for
// patterns of up to PAT_MAX characters. Pattern elements are literals,
// '.' (any one char), a leading '^' (word start), a trailing '$' (word end)
// and at most one '*' (any run of characters). For each pattern a one-cycle
// valid pulse reports match and the leftmost match start.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   chardata     in   [7:0] string or pattern character
//   isstring     in   chardata carries a string character
//   ispattern    in   chardata carries a pattern character
//   valid        out  one-cycle result strobe
//   match        out  1 = pattern found
//   match_index  out  [4:0] start index of leftmost match (0 if none)
//
// Search strategy: the pattern is split into P1 (before '*', or all of the
// core when there is no '*') and P2 (after '*'). When P2 is non-empty the
// rightmost legal P2 position t_max is found first (scanning down), then the
// leftmost P1 position s with s + len(P1) <= t_max (scanning up). The two
// scans together visit at most len - len(P1) - len(P2) + 2 positions.
// ---------------------------------------------------------------------------
module sme #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 chardata,
    input  logic                       isstring,
    input  logic                       ispattern,
    output logic                       valid,
    output logic                       match,
    output logic [$clog2(STR_MAX)-1:0] match_index
);

    localparam int SIW = $clog2(STR_MAX);      // string index width
    localparam int SLW = $clog2(STR_MAX + 1);  // string length width
    localparam int EW  = SLW + 1;              // width for position sums
    localparam int PIW = $clog2(PAT_MAX);      // pattern index width
    localparam int PLW = $clog2(PAT_MAX + 1);  // pattern length width

    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE,    // accept string characters or the first pattern character
        S_PAT,     // collecting pattern characters
        S_SCAN_T,  // searching downward for the rightmost P2 position
        S_SCAN_S   // searching upward for the leftmost P1 position
    } state_t;

    state_t r_state, w_state_nx;

    // Storage
    logic [7:0]     r_str [STR_MAX];
    logic [SLW-1:0] r_slen;
    logic           r_prev_str;
    logic [7:0]     r_pat [PAT_MAX];
    logic [PLW-1:0] r_plen;

    // Parsed pattern, captured when the pattern ends
    logic           r_anc_s, r_anc_e, r_has_star;
    logic [PLW-1:0] r_p1_off, r_a, r_p2_off, r_b;

    // Scan position and upper bound for the P1 scan
    logic [SLW-1:0] r_pos, r_limit;

    logic           r_valid, r_match;
    logic [SIW-1:0] r_index;

    // Combinational parse of the stored pattern
    logic           w_anc_s, w_anc_e, w_has_star;
    logic [PLW-1:0] w_core_lo, w_core_hi, w_star_pos;
    logic [PLW-1:0] w_p1_len, w_p2_off, w_p2_len;

    // Segment check at r_pos
    logic [PLW-1:0] w_off, w_slen;
    logic           w_chk_s, w_chk_e;
    logic [EW-1:0]  w_end, w_si;
    logic [PLW:0]   w_pi;
    logic           w_seg_ok;

    // Control outputs of the next-state logic
    logic           w_finish, w_found;
    logic [SIW-1:0] w_found_idx;
    logic [SLW-1:0] w_pos_nx, w_limit_nx;
    logic           w_str_we, w_pat_we;
    logic [SIW-1:0] w_str_addr;
    logic [PIW-1:0] w_pat_addr;

    // -----------------------------------------------------------------------
    // Pattern parse: anchors, core range, star position, segment lengths.
    // -----------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_anc_s    = (r_plen != '0) && (r_pat[0] == CH_CARET);
        // A lone '^' is the first element, never also a trailing '$'.
        w_anc_e    = (r_plen != '0) && (r_pat[PIW'(r_plen - PLW'(1))] == CH_DOLLAR)
                     && !(w_anc_s && (r_plen == PLW'(1)));
        w_core_lo  = w_anc_s ? PLW'(1) : '0;
        w_core_hi  = w_anc_e ? (r_plen - PLW'(1)) : r_plen;
        w_has_star = 1'b0;
        w_star_pos = '0;
        for (int k = 0; k < PAT_MAX; k++) begin
            if (!w_has_star && (PLW'(k) >= w_core_lo) && (PLW'(k) < w_core_hi)
                && (r_pat[PIW'(k)] == CH_STAR)) begin
                w_has_star = 1'b1;
                w_star_pos = PLW'(k);
            end
        end
        if (w_has_star) begin
            w_p1_len = w_star_pos - w_core_lo;
            w_p2_off = w_star_pos + PLW'(1);
            w_p2_len = w_core_hi - w_star_pos - PLW'(1);
        end else begin
            w_p1_len = w_core_hi - w_core_lo;
            w_p2_off = '0;
            w_p2_len = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Segment check: does the selected segment fit and match at r_pos,
    // including whichever anchor applies to it?
    // -----------------------------------------------------------------------
    always_comb begin
        if (r_state == S_SCAN_T) begin
            w_off   = r_p2_off;
            w_slen  = r_b;
            w_chk_s = 1'b0;
            w_chk_e = r_anc_e;
        end else begin
            w_off   = r_p1_off;
            w_slen  = r_a;
            w_chk_s = r_anc_s;
            w_chk_e = r_anc_e && !r_has_star;  // '$' binds to P2 when '*' exists
        end
        w_end    = EW'(r_pos) + EW'(w_slen);
        w_seg_ok = (w_end <= EW'(r_slen));
        w_pi     = '0;
        w_si     = '0;
        for (int k = 0; k < PAT_MAX; k++) begin
            if (PLW'(k) < w_slen) begin
                w_pi = (PLW+1)'(w_off) + (PLW+1)'(k);
                w_si = EW'(r_pos) + EW'(k);
                if ((w_pi >= (PLW+1)'(PAT_MAX)) || (w_si >= EW'(r_slen))) begin
                    w_seg_ok = 1'b0;
                end else if ((r_pat[PIW'(w_pi)] != CH_DOT)
                             && (r_pat[PIW'(w_pi)] != r_str[SIW'(w_si)])) begin
                    w_seg_ok = 1'b0;
                end
            end
        end
        if (w_chk_s && (r_pos != '0) && (r_str[SIW'(r_pos - SLW'(1))] != CH_SPACE)) begin
            w_seg_ok = 1'b0;
        end
        if (w_chk_e && (w_end < EW'(r_slen)) && (r_str[SIW'(w_end)] != CH_SPACE)) begin
            w_seg_ok = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and scan control
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nx  = r_state;
        w_finish    = 1'b0;
        w_found     = 1'b0;
        w_found_idx = '0;
        w_pos_nx    = r_pos;
        w_limit_nx  = r_limit;
        case (r_state)
            S_IDLE: begin
                if (ispattern) begin
                    w_state_nx = S_PAT;
                end
            end
            S_PAT: begin
                if (!ispattern) begin
                    w_limit_nx = r_slen - SLW'(w_p1_len);
                    w_pos_nx   = '0;
                    if (!w_has_star && (w_p1_len == '0)) begin
                        // Only anchors: trivially matches at 0.
                        w_finish   = 1'b1;
                        w_found    = 1'b1;
                        w_state_nx = S_IDLE;
                    end else if ((EW'(w_p1_len) + EW'(w_p2_len)) > EW'(r_slen)) begin
                        w_finish   = 1'b1;
                        w_state_nx = S_IDLE;
                    end else if (w_has_star && (w_p2_len != '0)) begin
                        w_pos_nx   = r_slen - SLW'(w_p2_len);
                        w_state_nx = S_SCAN_T;
                    end else begin
                        w_state_nx = S_SCAN_S;
                    end
                end
            end
            S_SCAN_T: begin
                if (w_seg_ok) begin
                    w_limit_nx = r_pos - SLW'(r_a);
                    w_pos_nx   = '0;
                    w_state_nx = S_SCAN_S;
                end else if (r_pos <= SLW'(r_a)) begin
                    // No room left for P1 in front of any P2 position.
                    w_finish   = 1'b1;
                    w_state_nx = S_IDLE;
                end else begin
                    w_pos_nx = r_pos - SLW'(1);
                end
            end
            S_SCAN_S: begin
                if (w_seg_ok) begin
                    w_finish    = 1'b1;
                    w_found     = 1'b1;
                    w_found_idx = SIW'(r_pos);
                    w_state_nx  = S_IDLE;
                end else if (r_pos >= r_limit) begin
                    w_finish   = 1'b1;
                    w_state_nx = S_IDLE;
                end else begin
                    w_pos_nx = r_pos + SLW'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Write-port control for the character stores
    always_comb begin
        w_str_we   = (r_state == S_IDLE) && isstring
                     && (!r_prev_str || (r_slen < SLW'(STR_MAX)));
        w_str_addr = r_prev_str ? SIW'(r_slen) : '0;
        w_pat_we   = ispattern && ((r_state == S_IDLE)
                     || ((r_state == S_PAT) && (r_plen < PLW'(PAT_MAX))));
        w_pat_addr = (r_state == S_IDLE) ? '0 : PIW'(r_plen);
    end

    // NOTE: sequential blocks use non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slen     <= '0;
            r_prev_str <= 1'b0;
            r_plen     <= '0;
            r_anc_s    <= 1'b0;
            r_anc_e    <= 1'b0;
            r_has_star <= 1'b0;
            r_p1_off   <= '0;
            r_a        <= '0;
            r_p2_off   <= '0;
            r_b        <= '0;
            r_pos      <= '0;
            r_limit    <= '0;
            r_valid    <= 1'b0;
            r_match    <= 1'b0;
            r_index    <= '0;
        end else begin
            r_prev_str <= isstring;
            r_pos      <= w_pos_nx;
            r_limit    <= w_limit_nx;
            r_valid    <= w_finish;
            if (w_finish) begin
                r_match <= w_found;
                r_index <= w_found_idx;
            end
            if ((r_state == S_IDLE) && isstring) begin
                // A new run of string cycles replaces the previous string.
                if (!r_prev_str) begin
                    r_slen <= SLW'(1);
                end else if (r_slen < SLW'(STR_MAX)) begin
                    r_slen <= r_slen + SLW'(1);
                end
            end
            if ((r_state == S_IDLE) && ispattern) begin
                r_plen <= PLW'(1);
            end else if (w_pat_we) begin
                r_plen <= r_plen + PLW'(1);
            end
            if ((r_state == S_PAT) && !ispattern) begin
                r_anc_s    <= w_anc_s;
                r_anc_e    <= w_anc_e;
                r_has_star <= w_has_star;
                r_p1_off   <= w_core_lo;
                r_a        <= w_p1_len;
                r_p2_off   <= w_p2_off;
                r_b        <= w_p2_len;
            end
        end
    end

    // NOTE: character stores are not reset; the length registers define
    // which entries are meaningful, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (w_str_we) begin
            r_str[w_str_addr] <= chardata;
        end
        if (w_pat_we) begin
            r_pat[w_pat_addr] <= chardata;
        end
    end

    assign valid       = r_valid;
    assign match       = r_match;
    assign match_index = r_index;

endmodule

// File: tb/tb_sme.sv
// ---------------------------------------------------------------------------
// tb_sme - directed testbench for sme
//
// Drives strings and patterns through the byte-serial interface and checks
// each result against hand-computed expectations. Inputs change 1 time unit
// after the rising edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_sme;

    logic       clk;
    logic       reset;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       valid;
    logic       match;
    logic [4:0] match_index;

    int n_cmp = 0;
    int n_bad = 0;

    sme #(.STR_MAX(32), .PAT_MAX(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .chardata    (chardata),
        .isstring    (isstring),
        .ispattern   (ispattern),
        .valid       (valid),
        .match       (match),
        .match_index (match_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_string(input string s);
        for (int i = 0; i < s.len(); i++) begin
            isstring = 1'b1;
            chardata = s[i];
            tick();
        end
        isstring = 1'b0;
        chardata = 8'h00;
        tick();
    endtask

    // Send a pattern, wait (bounded) for the valid pulse and check the result.
    // With check_gap set, also check that valid drops on the next cycle.
    task automatic run_pattern(input string name, input string p,
                               input logic exp_m, input logic [4:0] exp_i,
                               input bit check_gap);
        bit seen;
        int waited;
        for (int i = 0; i < p.len(); i++) begin
            ispattern = 1'b1;
            chardata  = p[i];
            tick();
        end
        ispattern = 1'b0;
        chardata  = 8'h00;
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < 64) begin
            tick();
            waited++;
            if (valid === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s valid: got no pulse in 64 cycles, wanted one", name);
        end else begin
            n_cmp++;
            if (match !== exp_m) begin
                n_bad++;
                $display("FAIL %s match: got %0b, wanted %0b", name, match, exp_m);
            end
            n_cmp++;
            if (match_index !== exp_i) begin
                n_bad++;
                $display("FAIL %s index: got %0d, wanted %0d", name, match_index, exp_i);
            end
            if (check_gap) begin
                tick();
                n_cmp++;
                if (valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s pulse width: valid got %0b, wanted 0", name, valid);
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_cmp++;
        if (valid !== 1'b0 || match !== 1'b0 || match_index !== 5'd0) begin
            n_bad++;
            $display("FAIL %s: got valid=%0b match=%0b index=%0d, wanted 0/0/0",
                     name, valid, match, match_index);
        end
    endtask

    task automatic expect_no_pulse(input string name, input int cycles);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (valid === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL %s: got %0d valid pulses, wanted 0", name, pulses);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        isstring  = 1'b0;
        ispattern = 1'b0;
        chardata  = 8'h00;
        repeat (3) tick();
        check_idle_outputs("reset_state");
        reset = 1'b0;
        tick();
        // Empty string after reset: a one-char pattern cannot fit.
        run_pattern("empty_string", "a", 1'b0, 5'd0, 1'b1);
    endtask

    task automatic test_basic();
        load_string("abcde");
        run_pattern("abcde_cd", "cd", 1'b1, 5'd2, 1'b1);
        run_pattern("abcde_ce", "ce", 1'b0, 5'd0, 1'b1);
    endtask

    task automatic test_anchor_start();
        load_string("hello world");
        run_pattern("hw_^wor", "^wor", 1'b1, 5'd6, 1'b1);
        run_pattern("hw_^orl", "^orl", 1'b0, 5'd0, 1'b1);
        run_pattern("hw_o w",  "o w",  1'b1, 5'd4, 1'b1);
    endtask

    task automatic test_anchor_end();
        run_pattern("hw_lo$",  "lo$",  1'b1, 5'd3, 1'b1);
        run_pattern("hw_rld$", "rld$", 1'b1, 5'd8, 1'b1);
        run_pattern("hw_wo$",  "wo$",  1'b0, 5'd0, 1'b1);
        run_pattern("hw_l.$",  "l.$",  1'b1, 5'd3, 1'b1);
    endtask

    task automatic test_wildcards();
        load_string("abcabc");
        run_pattern("abcabc_b.a", "b.a", 1'b1, 5'd1, 1'b1);
        run_pattern("abcabc_a*c", "a*c", 1'b1, 5'd0, 1'b1);
        run_pattern("abcabc_c*z", "c*z", 1'b0, 5'd0, 1'b1);
        run_pattern("abcabc_c*a", "c*a", 1'b1, 5'd2, 1'b1);
    endtask

    task automatic test_boundaries();
        load_string("xyd");
        run_pattern("xyd_*d",    "*d",   1'b1, 5'd0, 1'b1);
        run_pattern("xyd_^",     "^",    1'b1, 5'd0, 1'b1);
        run_pattern("xyd_$",     "$",    1'b1, 5'd0, 1'b1);
        run_pattern("xyd_toolong", "xydd", 1'b0, 5'd0, 1'b1);
        run_pattern("xyd_overrun", "yd.",  1'b0, 5'd0, 1'b1);
    endtask

    task automatic test_long_string();
        load_string("abcdefghijklmnopqrstuvwxyz012345");
        run_pattern("long_last8", "yz012345", 1'b1, 5'd24, 1'b1);
        load_string("xyz");
        run_pattern("short_yz",   "yz",  1'b1, 5'd1, 1'b1);
        run_pattern("short_012",  "012", 1'b0, 5'd0, 1'b1);
    endtask

    task automatic test_back_to_back();
        load_string("abcabc");
        run_pattern("b2b_abc", "abc", 1'b1, 5'd0, 1'b0);
        run_pattern("b2b_bca", "bca", 1'b1, 5'd1, 1'b0);
        run_pattern("b2b_cab", "cab", 1'b1, 5'd2, 1'b1);
    endtask

    task automatic test_reset_abort();
        // Abort while the pattern is still arriving.
        load_string("abcde");
        ispattern = 1'b1;
        chardata  = "c";
        tick();
        chardata  = "d";
        reset     = 1'b1;
        tick();
        ispattern = 1'b0;
        chardata  = 8'h00;
        tick();
        reset = 1'b0;
        check_idle_outputs("abort_pattern_outputs");
        expect_no_pulse("abort_pattern_pulse", 80);
        run_pattern("after_abort_len0", "a", 1'b0, 5'd0, 1'b1);

        // Abort during a long search.
        load_string("abcdefghijklmnopqrstuvwxyz012345");
        run_pattern("pre_abort_hit", "mno", 1'b1, 5'd12, 1'b1);
        ispattern = 1'b1;
        chardata  = "9";
        tick();
        ispattern = 1'b0;
        chardata  = 8'h00;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_outputs("abort_compute_outputs");
        expect_no_pulse("abort_compute_pulse", 80);
        load_string("abcde");
        run_pattern("after_abort_de", "de", 1'b1, 5'd3, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_anchor_start();
        test_anchor_end();
        test_wildcards();
        test_boundaries();
        test_long_string();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
